// File: rtl/imm_encoder_loader.sv
// imm_encoder_loader
//   Packs a 32-bit immediate into the immediate fields of an instruction word
//   for the requested ImmSrc format. Each result is written to instruction
//   memory at an auto-incrementing word address. This block is the inverse of
//   the immediate extender: extending the written word with the same ImmSrc
//   returns the original immediate.
//
//   Optional feature: define IMM_RANGE_CHECK_EN to reject immediates that do
//   not fit the format (code 10) or are misaligned (code 11). Without it,
//   excess bits are truncated and every legal-ImmSrc request is written.
//
// Ports
//   clk_i        clock, rising edge
//   reset_i      synchronous active-high reset
//   AddrClr_i    rewind write pointer to BASE_ADDR; clear Full/Error/ErrCode
//   InValid_i    request valid
//   InReady_o    request accepted when InValid_i && InReady_o
//   BaseInstr_i  opcode/reg/funct fields (imm bits of the format ignored)
//   ImmSrc_i     000 I, 001 S, 010 B, 011 J, 100 U, 101-111 illegal
//   Imm_i        immediate (byte offset for B/J)
//   MemWE_o      one-cycle instruction-memory write strobe
//   MemAddr_o    byte write address = BASE_ADDR + 4*WrIdx
//   MemWD_o      encoded instruction word
//   WordCnt_o    words written since reset/AddrClr
//   Full_o       WordCnt_o == DEPTH
//   Error_o      sticky error flag
//   ErrCode_o    first error: 01 illegal ImmSrc, 10 out of range, 11 misaligned
module imm_encoder_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          DEPTH     = 64,
  localparam int         IW        = $clog2(DEPTH),
  localparam int         CW        = IW + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          AddrClr_i,
  input  logic          InValid_i,
  output logic          InReady_o,
  input  logic [31:0]   BaseInstr_i,
  input  logic [2:0]    ImmSrc_i,
  input  logic [31:0]   Imm_i,
  output logic          MemWE_o,
  output logic [31:0]   MemAddr_o,
  output logic [31:0]   MemWD_o,
  output logic [CW-1:0] WordCnt_o,
  output logic          Full_o,
  output logic          Error_o,
  output logic [1:0]    ErrCode_o
);

  typedef enum logic [1:0] {IDLE, ENC, WRITE, ERR} state_t;

  localparam logic [2:0] SRC_I = 3'd0, SRC_S = 3'd1, SRC_B = 3'd2,
                         SRC_J = 3'd3, SRC_U = 3'd4;

  state_t        state_q, state_d;
  logic [31:0]   base_q, base_d, imm_q, imm_d;
  logic [2:0]    src_q, src_d;
  logic [IW-1:0] widx_q, widx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic [1:0]    pend_q, pend_d;   // code found in ENC, committed in ERR
  logic          memwe_q, memwe_d;
  logic [31:0]   memaddr_q, memaddr_d;
  logic [31:0]   memwd_q, memwd_d;
  logic [1:0]    chk_code;
  logic          full, hs;

  function automatic logic [31:0] encode(input logic [31:0] b,
                                         input logic [2:0]  s,
                                         input logic [31:0] i);
    logic [31:0] w;
    w = b;
    case (s)
      SRC_I: w[31:20] = i[11:0];
      SRC_S: begin w[31:25] = i[11:5]; w[11:7] = i[4:0]; end
      SRC_B: begin
        w[31] = i[12]; w[7] = i[11]; w[30:25] = i[10:5]; w[11:8] = i[4:1];
      end
      SRC_J: begin
        w[31] = i[20]; w[30:21] = i[10:1]; w[20] = i[11]; w[19:12] = i[19:12];
      end
      SRC_U: w[31:12] = i[31:12];
      default: ;
    endcase
    return w;
  endfunction

  // Returns 00 when legal, else the error code for this request.
  function automatic logic [1:0] check(input logic [2:0] s, input logic [31:0] i);
    logic [1:0] c;
    c = 2'b00;
    if (s > SRC_U) begin
      c = 2'b01;
    end else begin
`ifdef IMM_RANGE_CHECK_EN
      // Range failure outranks misalignment, so it is tested last.
      case (s)
        SRC_I, SRC_S: if (!((&i[31:11]) || !(|i[31:11]))) c = 2'b10;
        SRC_B: begin
          if (i[0]) c = 2'b11;
          if (!((&i[31:12]) || !(|i[31:12]))) c = 2'b10;
        end
        SRC_J: begin
          if (i[0]) c = 2'b11;
          if (!((&i[31:20]) || !(|i[31:20]))) c = 2'b10;
        end
        SRC_U: if (|i[11:0]) c = 2'b11;
        default: ;
      endcase
`else
      c = 2'b00;
`endif
    end
    return c;
  endfunction

  assign full      = (cnt_q == CW'(DEPTH));
  assign InReady_o = (state_q == IDLE) && !full && !AddrClr_i;
  assign hs        = InValid_i && InReady_o;
  assign chk_code  = check(src_q, imm_q);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    src_d     = src_q;
    imm_d     = imm_q;
    widx_d    = widx_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    code_d    = code_q;
    pend_d    = pend_q;
    memwe_d   = 1'b0;
    memaddr_d = memaddr_q;
    memwd_d   = memwd_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          base_d  = BaseInstr_i;
          src_d   = ImmSrc_i;
          imm_d   = Imm_i;
          state_d = ENC;
        end
      end
      ENC: begin
        if (chk_code != 2'b00) begin
          pend_d  = chk_code;
          state_d = ERR;
        end else begin
          memwe_d   = 1'b1;
          memwd_d   = encode(base_q, src_q, imm_q);
          memaddr_d = AddrClr_i ? BASE_ADDR
                                : BASE_ADDR + {{(30-IW){1'b0}}, widx_q, 2'b00};
          state_d   = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
        if (AddrClr_i) begin
          // The word on the bus this cycle is redirected to BASE_ADDR and
          // becomes the first word of the new window.
          memaddr_d = BASE_ADDR;
          widx_d    = IW'(1);
          cnt_d     = CW'(1);
        end else begin
          widx_d = widx_q + IW'(1);
          cnt_d  = cnt_q + CW'(1);
        end
      end
      ERR: begin
        state_d = IDLE;
        if (!err_q) begin
          err_d  = 1'b1;
          code_d = pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // Rewind wins over everything except the in-flight write accounting.
    if (AddrClr_i) begin
      err_d  = 1'b0;
      code_d = 2'b00;
      if (state_q != WRITE) begin
        widx_d = '0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      base_q    <= '0;
      src_q     <= '0;
      imm_q     <= '0;
      widx_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      code_q    <= '0;
      pend_q    <= '0;
      memwe_q   <= 1'b0;
      memaddr_q <= '0;
      memwd_q   <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      src_q     <= src_d;
      imm_q     <= imm_d;
      widx_q    <= widx_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      code_q    <= code_d;
      pend_q    <= pend_d;
      memwe_q   <= memwe_d;
      memaddr_q <= memaddr_d;
      memwd_q   <= memwd_d;
    end
  end

  assign MemWE_o   = memwe_q;
  // A rewind during WRITE redirects the current write, so the address
  // bypasses the register for that one cycle.
  assign MemAddr_o = (state_q == WRITE && AddrClr_i) ? BASE_ADDR : memaddr_q;
  assign MemWD_o   = memwd_q;
  assign WordCnt_o = cnt_q;
  assign Full_o    = full;
  assign Error_o   = err_q;
  assign ErrCode_o = code_q;

endmodule

// File: tb/tb_imm_encoder_loader.sv
module tb_imm_encoder_loader;
  localparam logic [31:0] BASE = 32'h100;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, reset = 1'b1, AddrClr = 1'b0, InValid = 1'b0;
  logic        InReady, MemWE, Full, Error;
  logic [31:0] BaseInstr = '0, Imm = '0, MemAddr, MemWD;
  logic [2:0]  ImmSrc = '0;
  logic [2:0]  WordCnt;
  logic [1:0]  ErrCode;

  int nerr = 0, nchk = 0;

  imm_encoder_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .reset_i(reset), .AddrClr_i(AddrClr), .InValid_i(InValid),
    .InReady_o(InReady), .BaseInstr_i(BaseInstr), .ImmSrc_i(ImmSrc), .Imm_i(Imm),
    .MemWE_o(MemWE), .MemAddr_o(MemAddr), .MemWD_o(MemWD), .WordCnt_o(WordCnt),
    .Full_o(Full), .Error_o(Error), .ErrCode_o(ErrCode));

  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic [31:0] base;
    logic [2:0]  src;
    logic [31:0] imm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        err;
    logic [1:0]  code;
    logic [2:0]  cnt;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic do_clr();
    @(negedge clk); AddrClr = 1'b1;
    @(negedge clk); AddrClr = 1'b0;
  endtask

  // Issue one request. clr_at: 0 none, 1 AddrClr during ENC, 2 during WRITE.
  // Returns what was seen on the memory port at N+2; returns at N+3.
  task automatic send(input logic [31:0] b, input logic [2:0] s, input logic [31:0] i,
                      input int clr_at, output logic we, output logic [31:0] a,
                      output logic [31:0] d);
    int n;
    @(negedge clk);
    BaseInstr = b; ImmSrc = s; Imm = i; InValid = 1'b1;
    n = 0;
    while (!InReady && n < 8) begin @(negedge clk); n++; end
    chk("handshake_ready", {31'b0, InReady}, 32'd1);
    @(posedge clk); #1;                     // cycle N handshake
    InValid = 1'b0;
    AddrClr = (clr_at == 1);
    @(negedge clk);                         // N+1
    chk("we_at_n1", {31'b0, MemWE}, 32'd0);
    @(posedge clk); #1;
    AddrClr = (clr_at == 2);
    @(negedge clk);                         // N+2
    we = MemWE; a = MemAddr; d = MemWD;
    @(posedge clk); #1;
    AddrClr = 1'b0;
    @(negedge clk);                         // N+3
  endtask

  initial begin
    logic        we;
    logic [31:0] a, d;

    tv[0] = '{1'b1, 32'h93,  3'd0, 32'hFFFFFFFF, 1'b1, BASE,       32'hFFF00093, 1'b0, 2'd0, 3'd1};
    tv[1] = '{1'b0, 32'h63,  3'd2, 32'h8,        1'b1, BASE + 4,   32'h00000463, 1'b0, 2'd0, 3'd2};
    tv[2] = '{1'b0, 32'hEF,  3'd3, 32'h800,      1'b1, BASE + 8,   32'h001000EF, 1'b0, 2'd0, 3'd3};
    tv[3] = '{1'b0, 32'h2B7, 3'd4, 32'h12345000, 1'b1, BASE + 12,  32'h123452B7, 1'b0, 2'd0, 3'd4};
    tv[4] = '{1'b1, 32'h23,  3'd1, 32'hFFFFFFFC, 1'b1, BASE,       32'hFE000E23, 1'b0, 2'd0, 3'd1};
    tv[5] = '{1'b0, 32'h63,  3'd2, 32'hFFFFFFFE, 1'b1, BASE + 4,   32'hFE000FE3, 1'b0, 2'd0, 3'd2};
`ifdef IMM_RANGE_CHECK_EN
    tv[6] = '{1'b0, 32'h93,  3'd0, 32'h800,      1'b0, 32'h0,      32'h0,        1'b1, 2'd2, 3'd2};
    tv[7] = '{1'b0, 32'h13,  3'd7, 32'h0,        1'b0, 32'h0,      32'h0,        1'b1, 2'd2, 3'd2};
`else
    tv[6] = '{1'b0, 32'h93,  3'd0, 32'h800,      1'b1, BASE + 8,   32'h80000093, 1'b0, 2'd0, 3'd3};
    tv[7] = '{1'b0, 32'h13,  3'd7, 32'h0,        1'b0, 32'h0,      32'h0,        1'b1, 2'd1, 3'd3};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready",   {31'b0, InReady}, 32'd1);
    chk("rst_we",      {31'b0, MemWE},   32'd0);
    chk("rst_addr",    MemAddr,          32'd0);
    chk("rst_wd",      MemWD,            32'd0);
    chk("rst_cnt",     {29'b0, WordCnt}, 32'd0);
    chk("rst_full",    {31'b0, Full},    32'd0);
    chk("rst_err",     {31'b0, Error},   32'd0);
    chk("rst_code",    {30'b0, ErrCode}, 32'd0);

    // Table vectors
    for (int k = 0; k < 8; k++) begin
      if (tv[k].clr) do_clr();
      send(tv[k].base, tv[k].src, tv[k].imm, 0, we, a, d);
      chk($sformatf("v%0d_we", k), {31'b0, we}, {31'b0, tv[k].we});
      if (tv[k].we) begin
        chk($sformatf("v%0d_addr", k), a, tv[k].addr);
        chk($sformatf("v%0d_wd", k),   d, tv[k].wd);
      end
      chk($sformatf("v%0d_err", k),  {31'b0, Error},   {31'b0, tv[k].err});
      chk($sformatf("v%0d_code", k), {30'b0, ErrCode}, {30'b0, tv[k].code});
      chk($sformatf("v%0d_cnt", k),  {29'b0, WordCnt}, {29'b0, tv[k].cnt});
    end

    // AddrClr clears the sticky error
    do_clr();
    chk("clr_err",  {31'b0, Error},   32'd0);
    chk("clr_code", {30'b0, ErrCode}, 32'd0);

    // Fill the window with 4 writes, then a 5th request is held off
    for (int k = 0; k < DEPTH; k++) begin
      send(32'h93, 3'd0, k, 0, we, a, d);
      chk($sformatf("fill%0d_addr", k), a, BASE + 4 * k);
      chk($sformatf("fill%0d_wd", k), d, {k[11:0], 20'h00093});
    end
    chk("full_flag", {31'b0, Full}, 32'd1);
    chk("full_cnt",  {29'b0, WordCnt}, 32'd4);
    @(negedge clk);
    BaseInstr = 32'h93; ImmSrc = 3'd0; Imm = 32'd5; InValid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("full_ready", {31'b0, InReady}, 32'd0);
      chk("full_we",    {31'b0, MemWE},   32'd0);
    end
    // AddrClr while still valid: clear wins, nothing accepted
    AddrClr = 1'b1; #1;
    chk("clr_ready", {31'b0, InReady}, 32'd0);
    @(negedge clk);
    AddrClr = 1'b0; InValid = 1'b0;
    chk("clr_cnt",  {29'b0, WordCnt}, 32'd0);
    chk("clr_full", {31'b0, Full},    32'd0);
    @(negedge clk);
    chk("clr_noacc_we", {31'b0, MemWE}, 32'd0);
    send(32'h93, 3'd0, 32'd5, 0, we, a, d);
    chk("fifth_we",   {31'b0, we}, 32'd1);
    chk("fifth_addr", a, BASE);
    chk("fifth_wd",   d, 32'h00500093);
    chk("fifth_cnt",  {29'b0, WordCnt}, 32'd1);

    // AddrClr during ENC: word lands at BASE, count restarts at 1
    send(32'h93, 3'd0, 32'd6, 1, we, a, d);
    chk("clrenc_we",   {31'b0, we}, 32'd1);
    chk("clrenc_addr", a, BASE);
    chk("clrenc_wd",   d, 32'h00600093);
    chk("clrenc_cnt",  {29'b0, WordCnt}, 32'd1);

    // AddrClr during WRITE: current write redirected to BASE
    send(32'h93, 3'd0, 32'd7, 2, we, a, d);
    chk("clrwr_we",   {31'b0, we}, 32'd1);
    chk("clrwr_addr", a, BASE);
    chk("clrwr_wd",   d, 32'h00700093);
    chk("clrwr_cnt",  {29'b0, WordCnt}, 32'd1);

    // Reset in the middle of ENC drops the request
    @(negedge clk);
    BaseInstr = 32'h93; ImmSrc = 3'd0; Imm = 32'd9; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0; reset = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstenc_we_n2", {31'b0, MemWE}, 32'd0);
    @(negedge clk);
    chk("rstenc_we_n3", {31'b0, MemWE},   32'd0);
    chk("rstenc_cnt",   {29'b0, WordCnt}, 32'd0);
    chk("rstenc_ready", {31'b0, InReady}, 32'd1);
    chk("rstenc_addr",  MemAddr,          32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
